// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with per-lane write masking and a
// sequential clear engine. Used as level/peak-history storage behind the
// VU meter datapath. The array is zeroed one word per cycle after reset or
// on request, and o_busy keeps user traffic out while that happens.
module ram_dp_clr #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 8,
  parameter int LANES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wen,
  input  logic [ADDR-1:0]    i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [LANES-1:0]   i_wmask,
  input  logic               i_ren,
  input  logic [ADDR-1:0]    i_raddr,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_rvalid,
  input  logic               i_clr,
  output logic               o_busy
);

  localparam int LW    = WIDTH / LANES;
  localparam int DEPTH = 1 << ADDR;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR-1:0]   clr_ptr;
  logic [ADDR-1:0]   clr_ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  merged_word;
  logic [WIDTH-1:0]  rd_word;
  logic              wr_en;
  logic              rd_en;

  // A clear request in the same cycle wins over a write, so the write is dropped
  assign wr_en  = (state == IDLE) && i_wen && !i_clr;
  assign rd_en  = (state == IDLE) && i_ren;
  assign o_busy = (state == CLEAR);

  // Next state and clear pointer; the last clear write hands the array back
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == {ADDR{1'b1}}) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (i_clr) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // State register; reset always restarts the clear from address 0
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Word as it will look after this cycle's masked write, for write-first reads
  always_comb begin
    merged_word = mem[i_waddr];
    for (int k = 0; k < LANES; k++) begin
      if (i_wmask[k]) begin
        merged_word[k*LW +: LW] = i_wdata[k*LW +: LW];
      end
    end
  end

  assign rd_word = (wr_en && (i_waddr == i_raddr)) ? merged_word : mem[i_raddr];

  // Array storage: clear engine writes zeros, otherwise masked user writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < LANES; k++) begin
          if (i_wmask[k]) begin
            mem[i_waddr][k*LW +: LW] <= i_wdata[k*LW +: LW];
          end
        end
      end
    end
  end

  // Registered read port; o_rdata holds whenever no read is accepted
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else if (rd_en) begin
      o_rdata  <= rd_word;
      o_rvalid <= 1'b1;
    end else begin
      o_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed self-checking bench for ram_dp_clr: a 16x16 two-lane instance
// for the main behaviour and a 4x8 single-lane instance for streaming reads.
module tb_ram_dp_clr;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;

  logic        i_wen = 1'b0;
  logic [3:0]  i_waddr = '0;
  logic [15:0] i_wdata = '0;
  logic [1:0]  i_wmask = '0;
  logic        i_ren = 1'b0;
  logic [3:0]  i_raddr = '0;
  logic        i_clr = 1'b0;
  logic [15:0] o_rdata;
  logic        o_rvalid;
  logic        o_busy;

  logic        b_wen = 1'b0;
  logic [1:0]  b_waddr = '0;
  logic [7:0]  b_wdata = '0;
  logic [0:0]  b_wmask = '0;
  logic        b_ren = 1'b0;
  logic [1:0]  b_raddr = '0;
  logic        b_clr = 1'b0;
  logic [7:0]  b_rdata;
  logic        b_rvalid;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  ram_dp_clr #(.WIDTH(16), .ADDR(4), .LANES(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wmask(i_wmask),
    .i_ren(i_ren), .i_raddr(i_raddr),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .i_clr(i_clr), .o_busy(o_busy)
  );

  ram_dp_clr #(.WIDTH(8), .ADDR(2), .LANES(1)) dut_small (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wen(b_wen), .i_waddr(b_waddr), .i_wdata(b_wdata), .i_wmask(b_wmask),
    .i_ren(b_ren), .i_raddr(b_raddr),
    .o_rdata(b_rdata), .o_rvalid(b_rvalid),
    .i_clr(b_clr), .o_busy(b_busy)
  );

  // 10 ns clock
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle just after it
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of user traffic on the wide instance, then idle the inputs
  task automatic applyStimulus(input logic wen, input logic [3:0] waddr, input logic [15:0] wdata,
                               input logic [1:0] wmask, input logic ren, input logic [3:0] raddr,
                               input logic clr);
    i_wen = wen; i_waddr = waddr; i_wdata = wdata; i_wmask = wmask;
    i_ren = ren; i_raddr = raddr; i_clr = clr;
    tick();
    i_wen = 1'b0; i_wmask = '0; i_ren = 1'b0; i_clr = 1'b0;
  endtask

  // Count edges until o_busy drops (bounded), optionally hammering user ports
  task automatic waitIdle(input logic hammer, output int n, output int valids);
    n = 0;
    valids = 0;
    for (int c = 0; c < 100; c++) begin
      if (hammer) begin
        i_wen = 1'b1; i_waddr = 4'd2; i_wdata = 16'hAAAA; i_wmask = 2'b11;
        i_ren = 1'b1; i_raddr = 4'(c);
      end
      tick();
      n++;
      if (o_rvalid) valids++;
      if (!o_busy) break;
    end
    i_wen = 1'b0; i_wmask = '0; i_ren = 1'b0;
  endtask

  initial begin
    int n;
    int v;
    int seq [5];
    logic [7:0] e;

    // Power-up reset and the clear that follows it
    i_rst = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(o_busy), 32'd1);
    checkOutput("rst_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("rst_rdata", 32'(o_rdata), 32'd0);
    i_rst = 1'b1;
    waitIdle(1'b0, n, v);
    checkOutput("init_clear_cycles", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(a), 1'b0);
      checkOutput($sformatf("init_rvalid_%0d", a), 32'(o_rvalid), 32'd1);
      checkOutput($sformatf("init_rdata_%0d", a), 32'(o_rdata), 32'd0);
    end
    tick();
    checkOutput("rvalid_pulse_end", 32'(o_rvalid), 32'd0);

    // Masked writes
    applyStimulus(1'b1, 4'd3, 16'hA55A, 2'b11, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3, 1'b0);
    checkOutput("wr_full_rvalid", 32'(o_rvalid), 32'd1);
    checkOutput("wr_full_rdata", 32'(o_rdata), 32'hA55A);
    tick();
    checkOutput("wr_full_rvalid_drop", 32'(o_rvalid), 32'd0);
    checkOutput("wr_full_rdata_hold", 32'(o_rdata), 32'hA55A);
    applyStimulus(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3, 1'b0);
    checkOutput("wr_lane0_rdata", 32'(o_rdata), 32'hA534);
    applyStimulus(1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3, 1'b0);
    checkOutput("wr_nomask_rdata", 32'(o_rdata), 32'hA534);

    // Read-during-write is write-first, merged per lane
    applyStimulus(1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b1, 4'd5, 1'b0);
    checkOutput("rdw_full_rdata", 32'(o_rdata), 32'hBEEF);
    applyStimulus(1'b1, 4'd6, 16'hBEEF, 2'b10, 1'b1, 4'd6, 1'b0);
    checkOutput("rdw_lane1_rdata", 32'(o_rdata), 32'hBE00);
    applyStimulus(1'b1, 4'd8, 16'h1111, 2'b11, 1'b1, 4'd9, 1'b0);
    checkOutput("rw_diff_rdata", 32'(o_rdata), 32'h0000);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd8, 1'b0);
    checkOutput("rw_diff_stored", 32'(o_rdata), 32'h1111);

    // Clear request beats a concurrent write; busy blocks user traffic
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 4'(a), 16'(a), 2'b11, 1'b0, 4'd0, 1'b0);
    end
    applyStimulus(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b1, 4'd7, 1'b1);
    checkOutput("clr_read_old", 32'(o_rdata), 32'h0007);
    checkOutput("clr_busy", 32'(o_busy), 32'd1);
    waitIdle(1'b1, n, v);
    checkOutput("clr_cycles", 32'(n), 32'd16);
    checkOutput("clr_rvalid_count", 32'(v), 32'd0);
    checkOutput("clr_rdata_hold", 32'(o_rdata), 32'h0007);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(a), 1'b0);
      checkOutput($sformatf("clr_rdata_%0d", a), 32'(o_rdata), 32'd0);
    end

    // Reset during a read, and reset part-way through a clear
    applyStimulus(1'b1, 4'd1, 16'h5555, 2'b11, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd1, 1'b0);
    checkOutput("pre_rst_rdata", 32'(o_rdata), 32'h5555);
    i_rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd1, 1'b0);
    checkOutput("rst_read_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("rst_read_rdata", 32'(o_rdata), 32'd0);
    i_rst = 1'b1;
    repeat (8) tick();
    checkOutput("mid_clear_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    tick();
    checkOutput("mid_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    waitIdle(1'b1, n, v);
    checkOutput("restart_cycles", 32'(n), 32'd16);
    checkOutput("restart_rvalid_count", 32'(v), 32'd0);
    applyStimulus(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd1, 1'b0);
    checkOutput("restart_rdata_1", 32'(o_rdata), 32'd0);

    // Narrow instance: continuous reads with address wrap
    checkOutput("small_idle", 32'(b_busy), 32'd0);
    for (int a = 0; a < 4; a++) begin
      b_wen = 1'b1; b_waddr = 2'(a); b_wdata = 8'(8'h10 + a); b_wmask = 1'b1;
      tick();
    end
    b_wen = 1'b0; b_wmask = 1'b0;
    seq = '{0, 1, 2, 3, 0};
    b_ren = 1'b1;
    b_raddr = 2'(seq[0]);
    tick();
    for (int i = 0; i < 5; i++) begin
      e = 8'(8'h10 + seq[i]);
      checkOutput($sformatf("stream_rvalid_%0d", i), 32'(b_rvalid), 32'd1);
      checkOutput($sformatf("stream_rdata_%0d", i), 32'(b_rdata), 32'(e));
      if (i < 4) begin
        b_raddr = 2'(seq[i+1]);
        tick();
      end
    end
    b_ren = 1'b0;
    tick();
    checkOutput("stream_rvalid_end", 32'(b_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
